// File: rtl/przesuniecie_sekw.sv
// Sequential shifter: SAL / SAR / SHR / ROL, one bit per clock, with
// start/busy/valid handshake and error/overflow flags for out-of-range amounts.
//
//   state | meaning
//   IDLE  | waiting for i_start; operands captured on the accepting edge
//   SHIFT | one bit per edge while counter != 0; loads outputs when it hits 0
//   DONE  | one-cycle o_valid pulse, then back to IDLE
module przesuniecie_sekw #(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_mode,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic [BITS-1:0] o_result,
    output logic            o_busy,
    output logic            o_valid,
    output logic            o_error,
    output logic            o_overflow
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [BITS-1:0] BITS_V = BITS'(BITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] MODE_SAL = 2'b00;
    localparam logic [1:0] MODE_SAR = 2'b01;
    localparam logic [1:0] MODE_SHR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      mode_q;
    logic [BITS-1:0] work_q;
    logic [BITS-1:0] shifted;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic            big_q;
    logic            sal_ovf_q;

    logic accept;
    logic step;
    logic last;
    logic arg_neg;
    logic arg_big;
    logic sign_loss;

    assign accept    = (state_q == IDLE) && i_start;
    assign step      = (state_q == SHIFT) && (cnt_q != '0);
    assign last      = (state_q == SHIFT) && (cnt_q == '0);
    assign arg_neg   = i_arg_B[BITS-1];
    assign arg_big   = !arg_neg && (i_arg_B > BITS_V);
    assign sign_loss = work_q[BITS-1] ^ work_q[BITS-2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                o_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        shifted = work_q;
        case (mode_q)
            MODE_SAL: shifted = {work_q[BITS-2:0], 1'b0};
            MODE_SAR: shifted = {work_q[BITS-1], work_q[BITS-1:1]};
            MODE_SHR: shifted = {1'b0, work_q[BITS-1:1]};
            MODE_ROL: shifted = {work_q[BITS-2:0], work_q[BITS-1]};
            default:  shifted = work_q;
        endcase
    end

    // Out-of-range amounts load a zero count so SHIFT finishes on its first edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q     <= MODE_SAL;
            work_q     <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            big_q      <= 1'b0;
            sal_ovf_q  <= 1'b0;
            o_result   <= '0;
            o_error    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (accept) begin
                work_q    <= i_arg_A;
                mode_q    <= i_mode;
                neg_q     <= arg_neg;
                big_q     <= arg_big;
                sal_ovf_q <= 1'b0;
                cnt_q     <= (arg_neg || arg_big) ? '0 : i_arg_B[CW-1:0];
            end else if (step) begin
                work_q <= shifted;
                cnt_q  <= cnt_q - CNT_ONE;
                if ((mode_q == MODE_SAL) && sign_loss) begin
                    sal_ovf_q <= 1'b1;
                end
            end
            if (last) begin
                o_result   <= (neg_q || big_q) ? '0 : work_q;
                o_error    <= neg_q;
                o_overflow <= big_q || sal_ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_przesuniecie_sekw.sv
// Directed bench for przesuniecie_sekw (BITS=32): expected results are queued
// at issue and compared when o_valid appears, along with latency and flags.
module tb_przesuniecie_sekw;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] arg_a;
    logic [31:0] arg_b;
    logic [31:0] result;
    logic        busy;
    logic        valid;
    logic        error;
    logic        overflow;

    int n_cmp;
    int n_fail;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        err;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    przesuniecie_sekw #(.BITS(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_arg_A    (arg_a),
        .i_arg_B    (arg_b),
        .o_result   (result),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_error    (error),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one operation, pokes i_start during SHIFT and DONE (must be ignored),
    // then checks result, flags, latency and that outputs hold afterwards.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic e,
                          input logic o);
        exp_t x;
        exp_t got;
        int   k;
        bit   seen;
        x.tag = tag;
        x.res = r;
        x.err = e;
        x.ovf = o;
        x.lat = ($signed(b) < 0 || $signed(b) > 32) ? 1 : int'(b) + 1;
        sb.push_back(x);

        @(negedge clk);
        mode  = m;
        arg_a = a;
        arg_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);

        seen = 0;
        k    = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (valid) begin
                seen  = 1;
                start = 1'b1;
            end else if (k == 1) begin
                start = 1'b1;
                mode  = ~m;
                arg_a = ~a;
                arg_b = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_valid_seen"}, 64'(seen), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            check({got.tag, "_latency"}, 64'(k), 64'(got.lat));
            check({got.tag, "_result"}, 64'(result), 64'(got.res));
            check({got.tag, "_error"}, 64'(error), 64'(got.err));
            check({got.tag, "_overflow"}, 64'(overflow), 64'(got.ovf));
        end

        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_valid_one_cycle"}, 64'(valid), 64'd0);
        check({tag, "_idle_after_done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_no_restart"}, 64'(busy), 64'd0);
        check({tag, "_result_hold"}, 64'(result), 64'(r));
    endtask

    initial begin
        bit saw_valid;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        mode   = 2'b00;
        arg_a  = '0;
        arg_b  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_result", 64'(result), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sal_3_by_4",      2'b00, 32'h0000_0003, 32'd4,  32'h0000_0030, 1'b0, 1'b0);
        run_op("sar_min_31",      2'b01, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("shr_min_31",      2'b10, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0);
        run_op("rol_min_1",       2'b11, 32'h8000_0000, 32'd1,  32'h0000_0001, 1'b0, 1'b0);
        run_op("sal_sign_loss",   2'b00, 32'h4000_0000, 32'd1,  32'h8000_0000, 1'b0, 1'b1);
        run_op("sal_full_32",     2'b00, 32'h7FFF_FFFF, 32'd32, 32'h0000_0000, 1'b0, 1'b1);
        run_op("neg_amount",      2'b01, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        run_op("big_amount",      2'b11, 32'h1234_5678, 32'd33, 32'h0, 1'b0, 1'b1);
        run_op("neg_amount_sal",  2'b00, 32'h4000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        run_op("rol_full_32",     2'b11, 32'h1234_5678, 32'd32, 32'h1234_5678, 1'b0, 1'b0);
        run_op("sar_pos_32",      2'b01, 32'h7000_000F, 32'd32, 32'h0000_0000, 1'b0, 1'b0);
        run_op("shr_full_32",     2'b10, 32'hF000_0000, 32'd32, 32'h0000_0000, 1'b0, 1'b0);
        run_op("sar_neg_4",       2'b01, 32'hC000_0000, 32'd4,  32'hFC00_0000, 1'b0, 1'b0);
        run_op("sal_1_by_30",     2'b00, 32'h0000_0001, 32'd30, 32'h4000_0000, 1'b0, 1'b0);
        run_op("sal_1_by_31",     2'b00, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sal_sticky",      2'b00, 32'h4000_0001, 32'd2,  32'h0000_0004, 1'b0, 1'b1);
        run_op("shr_rot_check",   2'b11, 32'hA000_0001, 32'd4,  32'h0000_001A, 1'b0, 1'b0);

        // Interrupted operation: SAL 1 by 20, stray start at edge 3, reset at edge 8.
        @(negedge clk);
        mode  = 2'b00;
        arg_a = 32'h0000_0001;
        arg_b = 32'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_valid = 0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            start = (e == 3);
            if (e == 3) begin
                arg_a = 32'h0000_0005;
                arg_b = 32'd0;
            end
            rst = (e == 8);
            @(posedge clk);
            #1;
            if (valid) saw_valid = 1;
        end
        check("intr_result", 64'(result), 64'd0);
        check("intr_busy", 64'(busy), 64'd0);
        check("intr_valid", 64'(valid), 64'd0);
        check("intr_error", 64'(error), 64'd0);
        check("intr_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (valid) saw_valid = 1;
        end
        check("intr_no_valid", 64'(saw_valid), 64'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_over_start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        run_op("after_reset_b0",  2'b00, 32'h0000_0001, 32'd0, 32'h0000_0001, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/przesuniecie_sekw.md
PRZESUNIECIE_SEKW -- requirements
Module: przesuniecie_sekw

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning operand/result width in bits (BITS >= 4).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request to start an operation.
REQ-005 SHALL have port i_mode  input  2  operation select: 00 SAL, 01 SAR, 10 SHR (logical right), 11 ROL.
REQ-006 SHALL have port i_arg_A  input  BITS  operand, two's complement.
REQ-007 SHALL have port i_arg_B  input  BITS  shift amount, signed two's complement.
REQ-008 SHALL have port o_result  output  BITS  shifted result.
REQ-009 SHALL have port o_busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse marking completed result.
REQ-011 SHALL have port o_error  output  1  negative shift amount.
REQ-012 SHALL have port o_overflow  output  1  SAL sign loss, or shift amount > BITS.

Function
REQ-013 SHALL implement FSM with states IDLE, SHIFT, DONE.
REQ-014 In IDLE, i_start=1 at an edge SHALL capture i_arg_A, i_arg_B and i_mode into internal registers and enter SHIFT.
REQ-015 i_start SHALL be ignored in SHIFT and DONE; captured operands SHALL not change until the next accepted start.
REQ-016 Shift counter SHALL be $clog2(BITS+1) bits wide, loaded with i_arg_B when 0 <= i_arg_B <= BITS.
REQ-017 In SHIFT, at each edge with counter != 0: shift the working register by one bit per i_mode and decrement the counter.
REQ-018 In SHIFT, at the edge where counter == 0: enter DONE and load o_result, o_error and o_overflow from the working values.
REQ-019 SAL SHALL fill with 0 at bit 0; SAR SHALL replicate bit BITS-1; SHR SHALL fill with 0 at bit BITS-1; ROL SHALL move bit BITS-1 into bit 0.
REQ-020 SAL overflow SHALL be sticky per operation: set if, at any step, bit BITS-1 != bit BITS-2 before that step.
REQ-021 SAR, SHR and ROL SHALL never set o_overflow for in-range shift amounts.
REQ-022 i_arg_B < 0 SHALL skip shifting and enter DONE at the first SHIFT edge with o_error=1, o_overflow=0, o_result=0.
REQ-023 i_arg_B > BITS SHALL skip shifting and enter DONE at the first SHIFT edge with o_error=0, o_overflow=1, o_result=0, in all modes.
REQ-024 Shift amount = BITS SHALL be executed normally: SAL and SHR give 0, SAR gives all copies of the sign bit, ROL gives A.
REQ-025 Latency: for in-range amount n, o_valid SHALL be high in the cycle following the (n+1)th edge after the accepting edge; error/overflow cases SHALL take n=0 timing.
REQ-026 DONE SHALL last exactly one cycle with o_valid=1, then return to IDLE; o_valid SHALL be 0 in all other states.
REQ-027 o_busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-028 o_result, o_error and o_overflow SHALL hold their values from DONE until the next DONE.
REQ-029 i_start high in the DONE cycle SHALL be ignored; it is accepted only from IDLE on a later edge.

Reset
REQ-030 i_rst=1 at an edge SHALL force IDLE and set o_result=0, o_busy=0, o_valid=0, o_error=0, o_overflow=0, counter=0, from any state.
REQ-031 i_rst SHALL take priority over i_start in the same cycle.
REQ-032 An operation interrupted by reset SHALL produce no o_valid pulse.

Verification
REQ-033 SAL, A=0x00000003, B=4 -> o_result=0x00000030, o_overflow=0, o_error=0, o_valid one cycle after the 5th edge following acceptance.
REQ-034 SAR, A=0x80000000, B=31 -> o_result=0xFFFFFFFF. Same A with SHR, B=31 -> 0x00000001. Same A with ROL, B=1 -> 0x00000001.
REQ-035 SAL, A=0x40000000, B=1 -> o_result=0x80000000, o_overflow=1. SAL, A=0x7FFFFFFF, B=32 -> o_result=0, o_overflow=1.
REQ-036 B=0xFFFFFFFF (-1) -> o_error=1, o_result=0, o_valid after the 2nd edge. B=33 -> o_overflow=1, o_result=0, same timing.
REQ-037 Start SAL, A=1, B=20. Pulse i_start again at edge 3 -> ignored. Assert i_rst at edge 8 -> all outputs 0, no o_valid. A new start with B=0 afterwards -> o_result=A, valid after the 2nd edge.
